// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S serial transmitter clocked by MCLK, one stereo holding slot.
// Optional I2S_TX_HOLD_LAST_EN: repeat the previous frame on underrun.
module i2s_tx #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic              MCLK,
  input  logic              MRST,
  input  logic              BCLK,
  input  logic              LRCLK,
  input  logic [DATA_W-1:0] S_L,
  input  logic [DATA_W-1:0] S_R,
  input  logic              S_VALID,
  output logic              S_READY,
  output logic              SDATA,
  output logic              UNDERRUN
);

  localparam logic [4:0] CNT_MAX = 5'(SLOT_W - 1);

  if (SLOT_W != 32) begin : g_bad_slot
    $error("i2s_tx: SLOT_W must be 32 to match the divider");
  end
  if (DATA_W < 8 || DATA_W > 31) begin : g_bad_width
    $error("i2s_tx: DATA_W must be within 8..31");
  end

  logic              bclk_dly_q, bclk_dly_d;
  logic              lr_dly_q, lr_dly_d;
  logic              hold_full_q, hold_full_d;
  logic              s_ready_q, s_ready_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] hold_r_q, hold_r_d;
  logic [DATA_W-1:0] frame_l_q, frame_l_d;
  logic [DATA_W-1:0] frame_r_q, frame_r_d;
  logic              synced_q, synced_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              sdata_q, sdata_d;
  logic              und_q, und_d;

  logic              fall;
  logic              lr_edge;
  logic              frame_start;
  logic              accept;
  logic [DATA_W-1:0] frame_ch;

  // Edge detection on the divider outputs and handshake qualification
  always_comb begin
    bclk_dly_d  = BCLK;
    lr_dly_d    = LRCLK;
    fall        = bclk_dly_q & ~BCLK;
    lr_edge     = fall & (lr_dly_q ^ LRCLK);
    frame_start = fall & lr_dly_q & ~LRCLK;
    accept      = S_VALID & s_ready_q;
  end

  // Holding register, frame load on LRCLK fall and underrun detection
  always_comb begin
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    frame_l_d   = frame_l_q;
    frame_r_d   = frame_r_q;
    und_d       = 1'b0;
    synced_d    = synced_q | frame_start;
    if (frame_start) begin
      if (hold_full_q) begin
        frame_l_d   = hold_l_q;
        frame_r_d   = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
`ifndef I2S_TX_HOLD_LAST_EN
        frame_l_d = '0;
        frame_r_d = '0;
`endif
        und_d = 1'b1;
      end
    end
    // a sample arriving on an empty frame_start is kept for the next frame
    if (accept) begin
      hold_l_d    = S_L;
      hold_r_d    = S_R;
      hold_full_d = 1'b1;
    end
    s_ready_d = ~hold_full_d;
  end

  // Slot bit counter and serial bit selection on each BCLK fall
  always_comb begin
    cnt_d    = cnt_q;
    sdata_d  = sdata_q;
    frame_ch = LRCLK ? frame_r_q : frame_l_q;
    if (fall && synced_d) begin
      if (lr_edge) begin
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 5'd1;
      end
      sdata_d = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
        if ({1'b0, cnt_d} == 6'(DATA_W - i)) begin
          sdata_d = frame_ch[i];
        end
      end
    end
  end

  // State registers
  always_ff @(posedge MCLK or negedge MRST) begin
    if (!MRST) begin
      bclk_dly_q  <= 1'b0;
      lr_dly_q    <= 1'b0;
      hold_full_q <= 1'b0;
      s_ready_q   <= 1'b1;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      frame_l_q   <= '0;
      frame_r_q   <= '0;
      synced_q    <= 1'b0;
      cnt_q       <= '0;
      sdata_q     <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      bclk_dly_q  <= bclk_dly_d;
      lr_dly_q    <= lr_dly_d;
      hold_full_q <= hold_full_d;
      s_ready_q   <= s_ready_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      frame_l_q   <= frame_l_d;
      frame_r_q   <= frame_r_d;
      synced_q    <= synced_d;
      cnt_q       <= cnt_d;
      sdata_q     <= sdata_d;
      und_q       <= und_d;
    end
  end

  assign S_READY  = s_ready_q;
  assign SDATA    = sdata_q;
  assign UNDERRUN = und_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx with an MCLK/4, MCLK/256 divider model.
// A second 16-bit instance covers the sign/padding case.
module tb_i2s_tx;

  logic        MCLK = 1'b0;
  logic        MRST = 1'b0;
  logic        BCLK;
  logic        LRCLK;
  logic [23:0] S_L = '0;
  logic [23:0] S_R = '0;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic        SDATA;
  logic        UNDERRUN;

  logic [15:0] l16 = 16'h8000;
  logic [15:0] r16 = 16'h0001;
  logic        v16 = 1'b1;
  logic        rdy16;
  logic        sd16;
  logic        und16;

  i2s_tx #(.DATA_W(24), .SLOT_W(32)) u_dut (
    .MCLK(MCLK), .MRST(MRST), .BCLK(BCLK), .LRCLK(LRCLK),
    .S_L(S_L), .S_R(S_R), .S_VALID(S_VALID), .S_READY(S_READY),
    .SDATA(SDATA), .UNDERRUN(UNDERRUN)
  );

  i2s_tx #(.DATA_W(16), .SLOT_W(32)) u_dut16 (
    .MCLK(MCLK), .MRST(MRST), .BCLK(BCLK), .LRCLK(LRCLK),
    .S_L(l16), .S_R(r16), .S_VALID(v16), .S_READY(rdy16),
    .SDATA(sd16), .UNDERRUN(und16)
  );

  always #5 MCLK = ~MCLK;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_und = 0;
  logic [7:0]  div = 8'd200;
  logic        prev_fs = 1'b0;
  logic        prev_acc = 1'b0;
  logic [23:0] prev_l = '0;
  logic [23:0] prev_r = '0;
  logic [47:0] pend[$];
  logic        model_synced = 1'b0;
  logic [23:0] frm_l = '0;
  logic [23:0] frm_r = '0;
  logic [31:0] slot_sr = '0;
  logic [31:0] slot16 = '0;
  logic        slot_chk = 1'b0;
  logic        slot16_chk = 1'b0;
  logic        chk16 = 1'b0;
  int          src_mode = 0;
  logic [23:0] seq = 24'd1;
  logic        offer_pending = 1'b0;
  logic [23:0] offer_l = '0;
  logic [23:0] offer_r = '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] slot24(input logic [23:0] v);
    return 32'(v) << 7;
  endfunction

  // one MCLK: observe the previous posedge, then drive the next one
  task automatic step();
    logic [47:0] f;
    logic        eu;
    logic [4:0]  b;
    @(negedge MCLK);
    eu = 1'b0;
    if (prev_fs) begin
      if (pend.size() > 0) begin
        f = pend.pop_front();
        frm_l = f[47:24];
        frm_r = f[23:0];
      end else begin
        eu = 1'b1;
`ifndef I2S_TX_HOLD_LAST_EN
        frm_l = '0;
        frm_r = '0;
`endif
      end
      model_synced = 1'b1;
    end
    if (prev_acc) begin
      pend.push_back({prev_l, prev_r});
      if (src_mode == 1) seq = seq + 24'd1;
      else offer_pending = 1'b0;
    end
    if (prev_fs || UNDERRUN) check("underrun", 32'(UNDERRUN), 32'(eu));
    if (UNDERRUN) n_und++;
    check("s_ready", 32'(S_READY), 32'(pend.size() == 0));
    if (!MRST) check("rst_sdata", 32'(SDATA), 32'd0);
    if (chk16 && prev_fs) check("u16_ready", 32'(rdy16), 32'd1);
    if (chk16) check("u16_underrun", 32'(und16), 32'd0);
    if (div[1:0] == 2'd1) begin
      b = div[6:2];
      if (b == 5'd0) begin
        slot_sr = '0;
        slot16 = '0;
        slot_chk = model_synced;
        slot16_chk = model_synced && chk16;
      end
      slot_sr = {slot_sr[30:0], SDATA};
      slot16 = {slot16[30:0], sd16};
      if (!model_synced) check("idle_sdata", 32'(SDATA), 32'd0);
      if (b == 5'd31 && slot_chk) begin
        if (div[7]) check("slot_r", slot_sr, slot24(frm_r));
        else check("slot_l", slot_sr, slot24(frm_l));
      end
      if (b == 5'd31 && slot16_chk) begin
        if (div[7]) check("u16_slot_r", slot16, 32'h0000_8000);
        else check("u16_slot_l", slot16, 32'h4000_0000);
      end
    end
    div = div + 8'd1;
    BCLK = div[1];
    LRCLK = div[7];
    prev_fs = MRST && (div == 8'd0);
    if (!MRST) begin
      S_VALID = 1'b0;
    end else if (src_mode == 1) begin
      S_VALID = 1'b1;
      S_L = seq;
      S_R = seq + 24'h100000;
    end else begin
      S_VALID = offer_pending;
      S_L = offer_l;
      S_R = offer_r;
    end
    prev_acc = MRST && S_VALID && S_READY;
    prev_l = S_L;
    prev_r = S_R;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic offer(input logic [23:0] l, input logic [23:0] r);
    offer_l = l;
    offer_r = r;
    offer_pending = 1'b1;
    for (int i = 0; i < 600 && offer_pending; i++) step();
    check("offer_accept", 32'(offer_pending), 32'd0);
    offer_pending = 1'b0;
  endtask

  task automatic wait_div(input logic [7:0] v);
    for (int i = 0; i < 300 && div != v; i++) step();
    check("div_align", 32'(div), 32'(v));
  endtask

  initial begin
    BCLK = div[1];
    LRCLK = div[7];
    run(4);
    check("rst_ready", 32'(S_READY), 32'd1);
    check("rst_sdata0", 32'(SDATA), 32'd0);
    check("rst_und", 32'(UNDERRUN), 32'd0);
    MRST = 1'b1;
    chk16 = 1'b1;

    // first frame offered before the first LRCLK fall
    offer(24'hABCDEF, 24'h123456);
    offer(24'h800001, 24'h7FFFFF);
    run(512);

    // starvation: one underrun per frame_start
    n_und = 0;
    run(768);
    check("und_count", 32'(n_und), 32'd3);
    chk16 = 1'b0;

    // back-to-back stream of incrementing samples
    src_mode = 1;
    seq = 24'd1;
    run(5 * 256);
    src_mode = 0;
    check("stream_progress", 32'(seq > 24'd5), 32'd1);
    run(512);

    // valid first raised exactly at frame_start with holding empty
    wait_div(8'hFF);
    offer_l = 24'h3C3C3C;
    offer_r = 24'hC3C3C3;
    offer_pending = 1'b1;
    step();
    step();
    check("fs_accept_und", 32'(UNDERRUN), 32'd1);
    check("fs_accept_pend", 32'(pend.size()), 32'd1);
    offer_pending = 1'b0;
    run(512);

    // reset in the middle of the left slot, bit 10
    offer(24'h111111, 24'h222222);
    run(256);
    wait_div(8'd40);
    MRST = 1'b0;
    pend.delete();
    model_synced = 1'b0;
    slot_chk = 1'b0;
    prev_acc = 1'b0;
    prev_fs = 1'b0;
    run(6);
    check("mid_rst_ready", 32'(S_READY), 32'd1);
    check("mid_rst_sdata", 32'(SDATA), 32'd0);
    MRST = 1'b1;
    offer(24'hA5A5A5, 24'h5A5A5A);
    run(3 * 256);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
